// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with valid/ready handshake, 2-entry skid buffer and sync flush.
// Optional perf counters (stall/flush) are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_buf #(
    parameter int unsigned          PC_W           = 32,
    parameter int unsigned          DW             = 32,
    parameter logic [PC_W-1:0]      PC_RESET_VAL   = '0,
    parameter logic [DW-1:0]        DATA_RESET_VAL = '0
`ifdef PIPE_STAGE_PERF_EN
    ,
    parameter int unsigned          CNT_W          = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [PC_W-1:0]   in_pc_i,
    input  logic [DW-1:0]     in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [PC_W-1:0]   out_pc_o,
    output logic [DW-1:0]     out_data_o
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [PC_W-1:0]   head_pc_q, head_pc_d;
    logic [DW-1:0]     head_data_q, head_data_d;
    logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
    logic [DW-1:0]     skid_data_q, skid_data_d;

    logic              in_fire;
    logic              out_fire;
    logic              out_valid;

    assign out_valid = (state_q != StEmpty);
    assign in_fire   = in_valid_i & in_ready_q;
    assign out_fire  = out_valid & out_ready_i;

    always_comb begin
        state_d     = state_q;
        head_pc_d   = head_pc_q;
        head_data_d = head_data_q;
        skid_pc_d   = skid_pc_q;
        skid_data_d = skid_data_q;

        unique case (state_q)
            StEmpty: begin
                if (in_fire) begin
                    state_d     = StOne;
                    head_pc_d   = in_pc_i;
                    head_data_d = in_data_i;
                end
            end
            StOne: begin
                if (in_fire && out_fire) begin
                    head_pc_d   = in_pc_i;
                    head_data_d = in_data_i;
                end else if (in_fire) begin
                    state_d     = StFull;
                    skid_pc_d   = in_pc_i;
                    skid_data_d = in_data_i;
                end else if (out_fire) begin
                    state_d     = StEmpty;
                    head_pc_d   = PC_RESET_VAL;
                    head_data_d = DATA_RESET_VAL;
                end
            end
            StFull: begin
                if (out_fire) begin
                    state_d     = StOne;
                    head_pc_d   = skid_pc_q;
                    head_data_d = skid_data_q;
                end
            end
            default: begin
                state_d     = StEmpty;
                head_pc_d   = PC_RESET_VAL;
                head_data_d = DATA_RESET_VAL;
            end
        endcase

        // Flush wins over everything; the head reloads the bubble values so outputs read as NOP.
        if (flush_i) begin
            state_d     = StEmpty;
            head_pc_d   = PC_RESET_VAL;
            head_data_d = DATA_RESET_VAL;
        end

        in_ready_d = (state_d != StFull);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StEmpty;
            in_ready_q  <= 1'b1;
            head_pc_q   <= PC_RESET_VAL;
            head_data_q <= DATA_RESET_VAL;
            skid_pc_q   <= PC_RESET_VAL;
            skid_data_q <= DATA_RESET_VAL;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            head_pc_q   <= head_pc_d;
            head_data_q <= head_data_d;
            skid_pc_q   <= skid_pc_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid;
    assign out_pc_o    = head_pc_q;
    assign out_data_o  = head_data_q;

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (out_valid && !out_ready_i) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (flush_i) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf; perf counters checked when PIPE_STAGE_PERF_EN is set.
module tb_pipe_stage_buf;

    localparam int unsigned     PC_W   = 32;
    localparam int unsigned     DW     = 32;
    localparam logic [31:0]     PC_RST = 32'hFFFF_FFF0;
    localparam logic [31:0]     D_RST  = 32'h0000_0013;
`ifdef PIPE_STAGE_PERF_EN
    localparam int unsigned     CNT_W  = 4;
`endif

    logic            clk;
    logic            rst;
    logic            flush_i;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [PC_W-1:0] in_pc_i;
    logic [DW-1:0]   in_data_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [PC_W-1:0] out_pc_o;
    logic [DW-1:0]   out_data_o;
`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    pipe_stage_buf #(
        .PC_W          (PC_W),
        .DW            (DW),
        .PC_RESET_VAL  (PC_RST),
        .DATA_RESET_VAL(D_RST)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .CNT_W         (CNT_W)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_pc_i    (in_pc_i),
        .in_data_i  (in_data_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_pc_o   (out_pc_o),
        .out_data_o (out_data_o)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt_o(stall_cnt_o),
        .flush_cnt_o(flush_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pay(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc);
        in_valid_i = 1'b1;
        in_pc_i    = pc;
        in_data_i  = pay(pc);
    endtask

    initial begin
        rst         = 1'b1;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        in_pc_i     = '0;
        in_data_i   = '0;
        out_ready_i = 1'b0;
        #12;
        rst = 1'b0;
        #1;
        chk("rst_valid", out_valid_o, 0);
        chk("rst_ready", in_ready_o, 1);
        chk("rst_pc", out_pc_o, PC_RST);
        chk("rst_data", out_data_o, D_RST);

        // Streaming at full rate
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(32'(i * 4));
            step();
            chk("str_valid", out_valid_o, 1);
            chk("str_pc", out_pc_o, 32'(i * 4));
            chk("str_data", out_data_o, pay(32'(i * 4)));
            chk("str_ready", in_ready_o, 1);
        end
        in_valid_i = 1'b0;
        step();
        chk("bubble_valid", out_valid_o, 0);
        chk("bubble_pc", out_pc_o, PC_RST);
        chk("bubble_data", out_data_o, D_RST);

        // Back-pressure fills the skid
        out_ready_i = 1'b0;
        push(32'h100);
        step();
        chk("bp1_ready", in_ready_o, 1);
        chk("bp1_pc", out_pc_o, 32'h100);
        push(32'h104);
        step();
        chk("bp2_ready", in_ready_o, 0);
        chk("bp2_pc", out_pc_o, 32'h100);
        push(32'h108);
        step();
        chk("bp3_ready", in_ready_o, 0);
        chk("bp3_pc", out_pc_o, 32'h100);
        chk("bp3_valid", out_valid_o, 1);
        out_ready_i = 1'b1;
        step();
        chk("drn1_pc", out_pc_o, 32'h104);
        chk("drn1_data", out_data_o, pay(32'h104));
        chk("drn1_ready", in_ready_o, 1);
        step();
        chk("drn2_pc", out_pc_o, 32'h108);
        chk("drn2_valid", out_valid_o, 1);
        in_valid_i = 1'b0;
        step();
        chk("drn3_valid", out_valid_o, 0);

        // Flush while FULL discards the incoming entry
        out_ready_i = 1'b0;
        push(32'h300);
        step();
        push(32'h304);
        step();
        chk("fl_full", in_ready_o, 0);
        push(32'h308);
        flush_i = 1'b1;
        step();
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        chk("fl_valid", out_valid_o, 0);
        chk("fl_ready", in_ready_o, 1);
        chk("fl_pc", out_pc_o, PC_RST);
        chk("fl_data", out_data_o, D_RST);
        step();
        chk("fl_nodup", out_valid_o, 0);

        // Asynchronous reset while FULL
        push(32'h400);
        step();
        push(32'h404);
        step();
        in_valid_i = 1'b0;
        chk("ar_full", in_ready_o, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", out_valid_o, 0);
        chk("ar_ready", in_ready_o, 1);
        chk("ar_pc", out_pc_o, PC_RST);
        rst = 1'b0;
        out_ready_i = 1'b1;
        push(32'h200);
        step();
        in_valid_i = 1'b0;
        chk("post_valid", out_valid_o, 1);
        chk("post_pc", out_pc_o, 32'h200);
        chk("post_data", out_data_o, pay(32'h200));
        step();
        chk("post_empty", out_valid_o, 0);

`ifdef PIPE_STAGE_PERF_EN
        rst = 1'b1;
        #1;
        rst = 1'b0;
        chk("perf_stall0", stall_cnt_o, 0);
        chk("perf_flush0", flush_cnt_o, 0);
        out_ready_i = 1'b0;
        push(32'h500);
        step();
        in_valid_i = 1'b0;
        for (int i = 0; i < 18; i++) begin
            step();
        end
        chk("perf_stall_wrap", stall_cnt_o, 2);
        for (int i = 0; i < 3; i++) begin
            flush_i = 1'b1;
            step();
            flush_i = 1'b0;
            step();
        end
        chk("perf_flush", flush_cnt_o, 3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
